// File: rtl/qea_pkg.sv
// ----------------------------------------------------------------------------
// qea_pkg : shared FSM encoding, fixed-point one and qubit range check
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package qea_pkg;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_LOAD_CTX   = 3'd1,
    S_INIT_STATE = 3'd2,
    S_START      = 3'd3,
    S_RUN        = 3'd4,
    S_READ       = 3'd5
  } state_e;

  // 1.0 in the default Q2.30 real/imag format
  localparam logic [31:0] ONE_FIXED = 32'h4000_0000;

  function automatic logic qbit_ok(input int unsigned qbit,
                                   input int unsigned pe_w,
                                   input int unsigned addr_w);
    return (qbit > pe_w) && (qbit <= addr_w + pe_w);
  endfunction

endpackage

`default_nettype wire

// File: rtl/qea_res_fifo.sv
// ----------------------------------------------------------------------------
// qea_res_fifo : small synchronous FIFO with occupancy count
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module qea_res_fifo #(
  parameter int WIDTH = 256,
  parameter int DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_push,
  input  logic [WIDTH-1:0]               i_data,
  input  logic                           i_pop,
  output logic [WIDTH-1:0]               o_data,
  output logic [$clog2(DEPTH+1)-1:0]     o_count
);

  localparam int c_aw = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_cw = $clog2(DEPTH+1);
  localparam logic [c_cw-1:0] c_full = c_cw'(DEPTH);
  localparam logic [c_aw-1:0] c_last = c_aw'(DEPTH-1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_aw-1:0]  r_wr_ptr;
  logic [c_aw-1:0]  r_rd_ptr;
  logic [c_cw-1:0]  r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_push = i_push && (r_count != c_full);
  assign w_do_pop  = i_pop && (r_count != '0);
  assign o_data    = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= (r_wr_ptr == c_last) ? '0 : r_wr_ptr + c_aw'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= (r_rd_ptr == c_last) ? '0 : r_rd_ptr + c_aw'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + c_cw'(1);
        2'b01:   r_count <= r_count - c_cw'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/qea_host_ctrl.sv
// ----------------------------------------------------------------------------
// qea_host_ctrl : loads context, seeds |0..0>, runs QEA and drains the state
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module qea_host_ctrl
  import qea_pkg::*;
#(
  parameter int PE_NUM_WIDTH            = 2,
  parameter int PE_NUM                  = 4,
  parameter int DATA_WIDTH              = 32,
  parameter int STATE_DATA_WIDTH        = 64,
  parameter int STATE_ADDR_WIDTH        = 16,
  parameter int GATE_CONTEXT_DATA_WIDTH = 64,
  parameter int GATE_CONTEXT_ADDR_WIDTH = 16,
  parameter int MAX_QBIT_WIDTH          = 6,
  parameter int NUM_FRAC_BIT            = 30,
  parameter int STATE_RD_LAT            = 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 i_cmd_valid,
  output logic                                 o_cmd_ready,
  input  logic [MAX_QBIT_WIDTH-1:0]            i_cmd_qbit_num,
  input  logic [GATE_CONTEXT_ADDR_WIDTH:0]     i_cmd_ins_num,
  input  logic                                 i_ctx_valid,
  output logic                                 o_ctx_ready,
  input  logic [GATE_CONTEXT_DATA_WIDTH-1:0]   i_ctx_data,
  output logic                                 o_res_valid,
  input  logic                                 i_res_ready,
  output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_res_data,
  output logic                                 o_res_last,
  output logic                                 o_busy,
  output logic                                 o_err,
  output logic [31:0]                          o_cycle_count,
  output logic                                 o_ctx_en,
  output logic                                 o_ctx_wea,
  output logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   o_ctx_addr,
  output logic [GATE_CONTEXT_DATA_WIDTH-1:0]   o_ctx_data,
  output logic                                 o_state_ena,
  output logic                                 o_state_wea,
  output logic [STATE_ADDR_WIDTH-1:0]          o_state_addra,
  output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_state_dina,
  output logic                                 o_start,
  input  logic                                 i_complete,
  input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]   i_state_dout
);

  localparam int c_word_w     = PE_NUM*STATE_DATA_WIDTH;
  localparam int c_fifo_depth = STATE_RD_LAT + 1;
  localparam int c_cnt_w      = $clog2(c_fifo_depth + 1);
  localparam logic [DATA_WIDTH-1:0] c_one_fixed =
    (DATA_WIDTH == 32 && NUM_FRAC_BIT == 30) ? DATA_WIDTH'(ONE_FIXED)
                                             : (DATA_WIDTH'(1) << NUM_FRAC_BIT);
  localparam logic [c_word_w-1:0] c_word0 = {c_one_fixed, {(c_word_w-DATA_WIDTH){1'b0}}};

  state_e                             r_state;
  logic [GATE_CONTEXT_ADDR_WIDTH:0]   r_ins_num;
  logic [GATE_CONTEXT_ADDR_WIDTH:0]   r_ctx_idx;
  logic [STATE_ADDR_WIDTH-1:0]        r_depth_m1;
  logic [STATE_ADDR_WIDTH-1:0]        r_addr;
  logic [STATE_ADDR_WIDTH-1:0]        r_out_idx;
  logic                               r_rd_all;
  logic                               r_armed;
  logic [31:0]                        r_cnt;
  logic [31:0]                        r_cycle_count;
  logic [STATE_RD_LAT-1:0]            r_rd_sh;
  logic                               r_err;
  logic                               r_ctx_en;
  logic [GATE_CONTEXT_ADDR_WIDTH-1:0] r_ctx_addr;
  logic [GATE_CONTEXT_DATA_WIDTH-1:0] r_ctx_data;

  logic                               w_qbit_ok;
  logic [STATE_ADDR_WIDTH-1:0]        w_depth_m1;
  logic                               w_issue;
  logic                               w_push;
  logic                               w_pop;
  logic                               w_res_valid;
  logic                               w_state_ena;
  logic [c_cnt_w-1:0]                 w_fifo_count;
  logic [c_word_w-1:0]                w_fifo_data;
  int                                 w_inflight;

  assign w_qbit_ok  = qbit_ok(32'(i_cmd_qbit_num), PE_NUM_WIDTH, STATE_ADDR_WIDTH);
  assign w_depth_m1 = STATE_ADDR_WIDTH'((32'd1 << (32'(i_cmd_qbit_num) - 32'(PE_NUM_WIDTH))) - 32'd1);

  // Credit counts a word leaving this cycle so back-to-back reads sustain full rate
  assign w_inflight  = $countones(r_rd_sh);
  assign w_res_valid = (r_state == S_READ) && (w_fifo_count != '0);
  assign w_pop       = w_res_valid && i_res_ready;
  assign w_push      = r_rd_sh[STATE_RD_LAT-1];
  assign w_issue     = (r_state == S_READ) && !r_rd_all &&
                       ((w_inflight + int'(w_fifo_count) - int'(w_pop)) < c_fifo_depth);

  assign w_state_ena   = (r_state == S_INIT_STATE) || w_issue;
  assign o_state_ena   = w_state_ena;
  assign o_state_wea   = (r_state == S_INIT_STATE);
  assign o_state_addra = w_state_ena ? r_addr : '0;
  assign o_state_dina  = ((r_state == S_INIT_STATE) && (r_addr == '0)) ? c_word0 : '0;

  assign o_cmd_ready   = (r_state == S_IDLE);
  assign o_ctx_ready   = (r_state == S_LOAD_CTX);
  assign o_busy        = (r_state != S_IDLE);
  assign o_start       = (r_state == S_START);
  assign o_err         = r_err;
  assign o_cycle_count = r_cycle_count;
  assign o_ctx_en      = r_ctx_en;
  assign o_ctx_wea     = r_ctx_en;
  assign o_ctx_addr    = r_ctx_addr;
  assign o_ctx_data    = r_ctx_data;

  assign o_res_valid = w_res_valid;
  assign o_res_data  = w_res_valid ? w_fifo_data : '0;
  assign o_res_last  = w_res_valid && (r_out_idx == r_depth_m1);

  qea_res_fifo #(
    .WIDTH (c_word_w),
    .DEPTH (c_fifo_depth)
  ) u_res_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (i_state_dout),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_count (w_fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_ins_num     <= '0;
      r_ctx_idx     <= '0;
      r_depth_m1    <= '0;
      r_addr        <= '0;
      r_out_idx     <= '0;
      r_rd_all      <= 1'b0;
      r_armed       <= 1'b0;
      r_cnt         <= '0;
      r_cycle_count <= '0;
      r_rd_sh       <= '0;
      r_err         <= 1'b0;
      r_ctx_en      <= 1'b0;
      r_ctx_addr    <= '0;
      r_ctx_data    <= '0;
    end else begin
      r_err    <= 1'b0;
      r_ctx_en <= 1'b0;
      r_rd_sh  <= (r_rd_sh << 1) | STATE_RD_LAT'(w_issue);

      case (r_state)
        S_IDLE: begin
          if (i_cmd_valid) begin
            if (w_qbit_ok) begin
              r_ins_num  <= i_cmd_ins_num;
              r_depth_m1 <= w_depth_m1;
              r_ctx_idx  <= '0;
              r_addr     <= '0;
              r_state    <= (i_cmd_ins_num == '0) ? S_INIT_STATE : S_LOAD_CTX;
            end else begin
              r_err <= 1'b1;
            end
          end
        end

        S_LOAD_CTX: begin
          if (i_ctx_valid) begin
            r_ctx_en   <= 1'b1;
            r_ctx_addr <= GATE_CONTEXT_ADDR_WIDTH'(r_ctx_idx);
            r_ctx_data <= i_ctx_data;
            r_ctx_idx  <= r_ctx_idx + (GATE_CONTEXT_ADDR_WIDTH+1)'(1);
            if (r_ctx_idx + (GATE_CONTEXT_ADDR_WIDTH+1)'(1) == r_ins_num) begin
              r_state <= S_INIT_STATE;
            end
          end
        end

        S_INIT_STATE: begin
          if (r_addr == r_depth_m1) begin
            r_addr  <= '0;
            r_cnt   <= 32'd1;
            r_state <= S_START;
          end else begin
            r_addr <= r_addr + STATE_ADDR_WIDTH'(1);
          end
        end

        S_START: begin
          r_cnt   <= r_cnt + 32'd1;
          r_armed <= 1'b0;
          r_state <= S_RUN;
        end

        S_RUN: begin
          if (r_cnt != '1) begin
            r_cnt <= r_cnt + 32'd1;
          end
          // complete is ignored in the first RUN cycle
          r_armed <= 1'b1;
          if (r_armed && i_complete) begin
            r_cycle_count <= r_cnt;
            r_addr        <= '0;
            r_rd_all      <= 1'b0;
            r_out_idx     <= '0;
            r_state       <= S_READ;
          end
        end

        S_READ: begin
          if (w_issue) begin
            if (r_addr == r_depth_m1) begin
              r_rd_all <= 1'b1;
            end else begin
              r_addr <= r_addr + STATE_ADDR_WIDTH'(1);
            end
          end
          if (w_pop) begin
            if (r_out_idx == r_depth_m1) begin
              r_state <= S_IDLE;
            end else begin
              r_out_idx <= r_out_idx + STATE_ADDR_WIDTH'(1);
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_qea_host_ctrl.sv
// ----------------------------------------------------------------------------
// tb_qea_host_ctrl : directed self-checking bench for qea_host_ctrl
// Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_qea_host_ctrl;

  localparam int W = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_cmd_valid;
  logic          o_cmd_ready;
  logic [5:0]    i_cmd_qbit_num;
  logic [16:0]   i_cmd_ins_num;
  logic          i_ctx_valid;
  logic          o_ctx_ready;
  logic [63:0]   i_ctx_data;
  logic          o_res_valid;
  logic          i_res_ready;
  logic [W-1:0]  o_res_data;
  logic          o_res_last;
  logic          o_busy;
  logic          o_err;
  logic [31:0]   o_cycle_count;
  logic          o_ctx_en;
  logic          o_ctx_wea;
  logic [15:0]   o_ctx_addr;
  logic [63:0]   o_ctx_data;
  logic          o_state_ena;
  logic          o_state_wea;
  logic [15:0]   o_state_addra;
  logic [W-1:0]  o_state_dina;
  logic          o_start;
  logic          i_complete;
  logic [W-1:0]  i_state_dout;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  qea_host_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .i_cmd_valid    (i_cmd_valid),
    .o_cmd_ready    (o_cmd_ready),
    .i_cmd_qbit_num (i_cmd_qbit_num),
    .i_cmd_ins_num  (i_cmd_ins_num),
    .i_ctx_valid    (i_ctx_valid),
    .o_ctx_ready    (o_ctx_ready),
    .i_ctx_data     (i_ctx_data),
    .o_res_valid    (o_res_valid),
    .i_res_ready    (i_res_ready),
    .o_res_data     (o_res_data),
    .o_res_last     (o_res_last),
    .o_busy         (o_busy),
    .o_err          (o_err),
    .o_cycle_count  (o_cycle_count),
    .o_ctx_en       (o_ctx_en),
    .o_ctx_wea      (o_ctx_wea),
    .o_ctx_addr     (o_ctx_addr),
    .o_ctx_data     (o_ctx_data),
    .o_state_ena    (o_state_ena),
    .o_state_wea    (o_state_wea),
    .o_state_addra  (o_state_addra),
    .o_state_dina   (o_state_dina),
    .o_start        (o_start),
    .i_complete     (i_complete),
    .i_state_dout   (i_state_dout)
  );

  function automatic logic [W-1:0] pat(input logic [15:0] a);
    return {8{24'hA5A5A5, a[7:0]}};
  endfunction

  // State RAM read port with one cycle of latency, returning an address tag
  always @(posedge clk) begin
    if (o_state_ena && !o_state_wea) i_state_dout <= pat(o_state_addra);
  end

  int          ctx_n = 0, st_n = 0, start_n = 0, port_n = 0;
  logic [15:0] ctx_addr [16];
  logic [63:0] ctx_data [16];
  logic [15:0] st_addr  [64];
  logic [W-1:0] st_data [64];

  always @(negedge clk) begin
    if (o_ctx_en || o_state_ena || o_start) port_n++;
    if (o_ctx_en && o_ctx_wea) begin
      if (ctx_n < 16) begin ctx_addr[ctx_n] = o_ctx_addr; ctx_data[ctx_n] = o_ctx_data; end
      ctx_n++;
    end
    if (o_state_ena && o_state_wea) begin
      if (st_n < 64) begin st_addr[st_n] = o_state_addra; st_data[st_n] = o_state_dina; end
      st_n++;
    end
    if (o_start) start_n++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int got, first, lastc, c0, s0, p0;
    logic stall_prev;
    logic [W-1:0] prev;
    logic [63:0] ctxw [3];
    logic [5:0]  badq [2];

    ctxw[0] = 64'h1111_2222_3333_4444;
    ctxw[1] = 64'h5555_6666_7777_8888;
    ctxw[2] = 64'h9999_AAAA_BBBB_CCCC;
    badq[0] = 6'd2;
    badq[1] = 6'd19;

    rst = 1'b1; i_cmd_valid = 1'b0; i_cmd_qbit_num = '0; i_cmd_ins_num = '0;
    i_ctx_valid = 1'b0; i_ctx_data = '0; i_res_ready = 1'b1; i_complete = 1'b0;
    repeat (3) tick();
    chk("rst_cmd_ready", o_cmd_ready, 1);
    chk("rst_busy", o_busy, 0);
    chk("rst_err", o_err, 0);
    chk("rst_cycle_count", o_cycle_count, 0);
    chk("rst_res_valid", o_res_valid, 0);
    chk("rst_ctx_ready", o_ctx_ready, 0);
    chk("rst_start", o_start, 0);
    chk("rst_state_ena", o_state_ena, 0);
    rst = 1'b0;
    tick();

    // Run 1: 4 qubits, three context words, complete 10 cycles after start
    i_cmd_valid = 1'b1; i_cmd_qbit_num = 6'd4; i_cmd_ins_num = 17'd3;
    tick();
    i_cmd_valid = 1'b0;
    chk("r1_busy", o_busy, 1);
    chk("r1_ctx_ready", o_ctx_ready, 1);
    chk("r1_cmd_ready", o_cmd_ready, 0);
    for (int k = 0; k < 3; k++) begin
      i_ctx_valid = 1'b1; i_ctx_data = ctxw[k];
      tick();
    end
    i_ctx_valid = 1'b0;
    for (int i = 0; i < 50 && o_start !== 1'b1; i++) tick();
    chk("r1_start_seen", o_start, 1);
    repeat (10) tick();
    i_complete = 1'b1;
    tick();
    i_complete = 1'b0;
    chk("r1_cycle_count", o_cycle_count, 11);
    chk("r1_ctx_n", ctx_n, 3);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("r1_ctx_addr%0d", k), ctx_addr[k], k);
      chk($sformatf("r1_ctx_data%0d", k), ctx_data[k], ctxw[k]);
    end
    chk("r1_st_n", st_n, 4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("r1_st_addr%0d", k), st_addr[k], k);
      chk($sformatf("r1_st_data%0d", k), st_data[k],
          (k == 0) ? {32'h4000_0000, 224'd0} : {W{1'b0}});
    end
    chk("r1_start_n", start_n, 1);

    got = 0; first = -1; lastc = -1;
    for (int i = 0; i < 60 && got < 4; i++) begin
      if (o_res_valid && i_res_ready) begin
        chk($sformatf("r1_res_data%0d", got), o_res_data, pat(16'(got)));
        chk($sformatf("r1_res_last%0d", got), o_res_last, (got == 3));
        if (got == 0) first = i;
        lastc = i;
        got++;
      end
      tick();
    end
    chk("r1_res_count", got, 4);
    chk("r1_res_rate", lastc - first, 3);
    chk("r1_idle_after", o_busy, 0);

    // Run 2: 5 qubits, no context, early complete ignored, ready toggling
    c0 = ctx_n; s0 = st_n;
    i_cmd_valid = 1'b1; i_cmd_qbit_num = 6'd5; i_cmd_ins_num = 17'd0;
    tick();
    i_cmd_valid = 1'b0;
    chk("r2_init_ena", o_state_ena, 1);
    chk("r2_init_wea", o_state_wea, 1);
    chk("r2_ctx_ready", o_ctx_ready, 0);
    for (int i = 0; i < 50 && o_start !== 1'b1; i++) tick();
    chk("r2_start_seen", o_start, 1);
    tick();
    i_complete = 1'b1;
    tick();
    i_complete = 1'b0;
    chk("r2_early_ignored", o_busy, 1);
    repeat (2) tick();
    i_complete = 1'b1;
    tick();
    i_complete = 1'b0;
    chk("r2_cycle_count", o_cycle_count, 5);
    chk("r2_no_ctx_writes", ctx_n - c0, 0);
    chk("r2_st_writes", st_n - s0, 8);

    got = 0; stall_prev = 1'b0; prev = '0; i_res_ready = 1'b1;
    for (int i = 0; i < 100 && got < 8; i++) begin
      if (stall_prev) begin
        chk("r2_stall_valid", o_res_valid, 1);
        chk("r2_stall_data", o_res_data, prev);
      end
      if (o_res_valid && i_res_ready) begin
        chk($sformatf("r2_res_data%0d", got), o_res_data, pat(16'(got)));
        chk($sformatf("r2_res_last%0d", got), o_res_last, (got == 7));
        got++;
      end
      stall_prev = o_res_valid && !i_res_ready;
      prev = o_res_data;
      tick();
      i_res_ready = !i_res_ready;
    end
    i_res_ready = 1'b1;
    chk("r2_res_count", got, 8);
    chk("r2_idle_after", o_busy, 0);
    chk("r2_no_extra", o_res_valid, 0);

    // Rejected commands
    for (int k = 0; k < 2; k++) begin
      p0 = port_n;
      i_cmd_valid = 1'b1; i_cmd_qbit_num = badq[k]; i_cmd_ins_num = 17'd3;
      tick();
      i_cmd_valid = 1'b0;
      chk($sformatf("err_pulse_q%0d", badq[k]), o_err, 1);
      chk($sformatf("err_busy_q%0d", badq[k]), o_busy, 0);
      chk($sformatf("err_ready_q%0d", badq[k]), o_cmd_ready, 1);
      tick();
      chk($sformatf("err_clear_q%0d", badq[k]), o_err, 0);
      chk($sformatf("err_no_ports_q%0d", badq[k]), port_n - p0, 0);
    end

    // Reset while running
    i_cmd_valid = 1'b1; i_cmd_qbit_num = 6'd3; i_cmd_ins_num = 17'd1;
    tick();
    i_cmd_valid = 1'b0;
    i_ctx_valid = 1'b1; i_ctx_data = 64'hDEAD_BEEF_0000_0001;
    tick();
    i_ctx_valid = 1'b0;
    for (int i = 0; i < 50 && o_start !== 1'b1; i++) tick();
    chk("rr_start_seen", o_start, 1);
    repeat (2) tick();
    chk("rr_in_run", o_busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rr_cmd_ready", o_cmd_ready, 1);
    chk("rr_busy", o_busy, 0);
    chk("rr_cycle_count", o_cycle_count, 0);
    chk("rr_start", o_start, 0);
    chk("rr_state_ena", o_state_ena, 0);
    chk("rr_ctx_en", o_ctx_en, 0);
    chk("rr_res_valid", o_res_valid, 0);
    i_complete = 1'b1;
    repeat (3) tick();
    i_complete = 1'b0;
    chk("rr_late_busy", o_busy, 0);
    chk("rr_late_res_valid", o_res_valid, 0);
    chk("rr_late_state_ena", o_state_ena, 0);
    chk("rr_late_cycle_count", o_cycle_count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
